case_select_monitor: RTL and testbench

- Registered, parametrised case-select engine that generalises the 2-bit/3-item unique, unique0 and priority case decode.
- Adds runtime-programmable item keys and data, a selectable qualifier mode, and sticky/counted violation reporting for no-match and multi-match events.
- Sits beside converted case logic as a checked reference decoder and as a run-time violation monitor.

---
 rtl/case_select_monitor.sv | 106 ++++++++++
 tb/tb_case_select_monitor.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/case_select_monitor.sv
// Registered case-select decoder with lowest-index-first selection and
// sticky / saturating-count reporting of no-match and multi-match events.
module case_select_monitor #(
  parameter int SEL_W     = 2,
  parameter int DATA_W    = 4,
  parameter int NUM_ITEMS = 3,
  parameter int MODE      = 0,
  parameter int CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [SEL_W-1:0]              select,
  input  logic [NUM_ITEMS*SEL_W-1:0]    item_key,
  input  logic [NUM_ITEMS*DATA_W-1:0]   item_data,
  input  logic [DATA_W-1:0]             default_data,
  input  logic                          clear,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             data,
  output logic [3:0]                    hit_idx,
  output logic                          no_match_flag,
  output logic                          multi_match_flag,
  output logic [CNT_W-1:0]              no_match_cnt,
  output logic [CNT_W-1:0]              multi_match_cnt
);

  // Unsupported qualifier codes fall back to unique.
  localparam int QMODE = (MODE == 1 || MODE == 2) ? MODE : 0;
  localparam bit CHK_NO    = (QMODE != 1);
  localparam bit CHK_MULTI = (QMODE != 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_ITEMS-1:0] match;
  logic [DATA_W-1:0]    sel_data;
  logic [3:0]           sel_idx;
  logic                 no_hit;
  logic                 multi_hit;
  logic                 no_viol;
  logic                 multi_viol;
  logic                 nm_flag_n;
  logic                 mm_flag_n;
  logic [CNT_W-1:0]     nm_cnt_n;
  logic [CNT_W-1:0]     mm_cnt_n;

  // Scan from the top down so the lowest matching index wins.
  always_comb begin
    match    = '0;
    sel_data = default_data;
    sel_idx  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      match[i] = (select == item_key[i*SEL_W +: SEL_W]);
    end
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_data = item_data[i*DATA_W +: DATA_W];
        sel_idx  = 4'(i);
      end
    end
  end

  assign no_hit     = (match == '0);
  assign multi_hit  = |(match & (match - NUM_ITEMS'(1)));
  assign no_viol    = in_valid & CHK_NO & no_hit;
  assign multi_viol = in_valid & CHK_MULTI & multi_hit;

  // Clear is applied first, so a violation in the same cycle survives it.
  always_comb begin
    nm_flag_n = clear ? 1'b0 : no_match_flag;
    mm_flag_n = clear ? 1'b0 : multi_match_flag;
    nm_cnt_n  = clear ? '0 : no_match_cnt;
    mm_cnt_n  = clear ? '0 : multi_match_cnt;
    if (no_viol) begin
      nm_flag_n = 1'b1;
      if (nm_cnt_n != CNT_MAX) nm_cnt_n = nm_cnt_n + CNT_W'(1);
    end
    if (multi_viol) begin
      mm_flag_n = 1'b1;
      if (mm_cnt_n != CNT_MAX) mm_cnt_n = mm_cnt_n + CNT_W'(1);
    end
  end

  // in_valid has no backpressure: every valid sample is accepted and
  // reappears one cycle later with out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid        <= 1'b0;
      data             <= '0;
      hit_idx          <= '0;
      no_match_flag    <= 1'b0;
      multi_match_flag <= 1'b0;
      no_match_cnt     <= '0;
      multi_match_cnt  <= '0;
    end else begin
      out_valid        <= in_valid;
      if (in_valid) begin
        data    <= sel_data;
        hit_idx <= sel_idx;
      end
      no_match_flag    <= nm_flag_n;
      multi_match_flag <= mm_flag_n;
      no_match_cnt     <= nm_cnt_n;
      multi_match_cnt  <= mm_cnt_n;
    end
  end

endmodule

// File: tb/tb_case_select_monitor.sv
// Bench for case_select_monitor: one instance per qualifier mode sharing
// stimulus, checked against constant tables and a reference model.
module tb_case_select_monitor;

  localparam int SEL_W = 2;
  localparam int DATA_W = 4;
  localparam int N = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] k [N];
  logic [DATA_W-1:0] d [N];
  logic [DATA_W-1:0] def;
  logic clr;
  logic [N*SEL_W-1:0] item_key;
  logic [N*DATA_W-1:0] item_data;

  logic o_ov [3];
  logic [DATA_W-1:0] o_data [3];
  logic [3:0] o_hit [3];
  logic o_nf [3];
  logic o_mf [3];
  logic [CNT_W-1:0] o_nc [3];
  logic [CNT_W-1:0] o_mc [3];

  int checks = 0;
  int errors = 0;

  // reference model state, one slot per mode
  int m_ov [3], m_data [3], m_hit [3], m_nf [3], m_mf [3], m_nc [3], m_mc [3];

  always #5 clk = ~clk;

  always_comb begin
    item_key = '0;
    item_data = '0;
    for (int i = 0; i < N; i++) begin
      item_key[i*SEL_W +: SEL_W] = k[i];
      item_data[i*DATA_W +: DATA_W] = d[i];
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    case_select_monitor #(
      .SEL_W(SEL_W), .DATA_W(DATA_W), .NUM_ITEMS(N), .MODE(g), .CNT_W(CNT_W)
    ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .select(sel),
      .item_key(item_key), .item_data(item_data), .default_data(def),
      .clear(clr), .out_valid(o_ov[g]), .data(o_data[g]), .hit_idx(o_hit[g]),
      .no_match_flag(o_nf[g]), .multi_match_flag(o_mf[g]),
      .no_match_cnt(o_nc[g]), .multi_match_cnt(o_mc[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_ov[m] = 0; m_data[m] = 0; m_hit[m] = 0;
      m_nf[m] = 0; m_mf[m] = 0; m_nc[m] = 0; m_mc[m] = 0;
    end
  endtask

  // Spec-level model: count matches, pick the first, apply clear then violations.
  task automatic model_step();
    int n, first;
    n = 0; first = -1;
    for (int i = 0; i < N; i++)
      if (sel == k[i]) begin
        n++;
        if (first < 0) first = i;
      end
    for (int m = 0; m < 3; m++) begin
      if (clr) begin
        m_nf[m] = 0; m_mf[m] = 0; m_nc[m] = 0; m_mc[m] = 0;
      end
      m_ov[m] = in_valid;
      if (in_valid) begin
        m_data[m] = (first >= 0) ? int'(d[first]) : int'(def);
        m_hit[m] = (first >= 0) ? first : 0;
        if (n == 0 && m != 1) begin
          m_nf[m] = 1;
          m_nc[m] = (m_nc[m] == 255) ? 255 : m_nc[m] + 1;
        end
        if (n >= 2 && m != 2) begin
          m_mf[m] = 1;
          m_mc[m] = (m_mc[m] == 255) ? 255 : m_mc[m] + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s m%0d out_valid", tag, m), int'(o_ov[m]), m_ov[m]);
      chk($sformatf("%s m%0d data", tag, m), int'(o_data[m]), m_data[m]);
      chk($sformatf("%s m%0d hit_idx", tag, m), int'(o_hit[m]), m_hit[m]);
      chk($sformatf("%s m%0d nm_flag", tag, m), int'(o_nf[m]), m_nf[m]);
      chk($sformatf("%s m%0d mm_flag", tag, m), int'(o_mf[m]), m_mf[m]);
      chk($sformatf("%s m%0d nm_cnt", tag, m), int'(o_nc[m]), m_nc[m]);
      chk($sformatf("%s m%0d mm_cnt", tag, m), int'(o_mc[m]), m_mc[m]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s m%0d out_valid", tag, m), int'(o_ov[m]), 0);
      chk($sformatf("%s m%0d data", tag, m), int'(o_data[m]), 0);
      chk($sformatf("%s m%0d hit_idx", tag, m), int'(o_hit[m]), 0);
      chk($sformatf("%s m%0d flags", tag, m), int'({o_nf[m], o_mf[m]}), 0);
      chk($sformatf("%s m%0d nm_cnt", tag, m), int'(o_nc[m]), 0);
      chk($sformatf("%s m%0d mm_cnt", tag, m), int'(o_mc[m]), 0);
    end
  endtask

  task automatic set_items(input int k0, input int k1, input int k2,
                           input int d0, input int d1, input int d2);
    k[0] = 2'(k0); k[1] = 2'(k1); k[2] = 2'(k2);
    d[0] = 4'(d0); d[1] = 4'(d1); d[2] = 4'(d2);
  endtask

  typedef struct {
    bit v; bit clr; int sel; bit dup;
    int e_ov; int e_data; int e_hit; int e_nc0; int e_mc1; int e_nc2;
  } vec_t;

  vec_t vt [10];

  initial begin
    // dup=0: keys {0,1,2}; dup=1: keys {1,1,2}; data {a,6,3}, default 0
    vt[0] = '{1, 0, 0, 0, 1, 10, 0, 0, 0, 0};
    vt[1] = '{1, 0, 1, 0, 1, 6, 1, 0, 0, 0};
    vt[2] = '{1, 0, 2, 0, 1, 3, 2, 0, 0, 0};
    vt[3] = '{1, 0, 3, 0, 1, 0, 0, 1, 0, 1};
    vt[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vt[5] = '{1, 0, 1, 1, 1, 10, 0, 1, 1, 1};
    vt[6] = '{1, 0, 3, 1, 1, 0, 0, 2, 1, 2};
    vt[7] = '{1, 1, 3, 1, 1, 0, 0, 1, 0, 1};
    vt[8] = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vt[9] = '{1, 0, 2, 1, 1, 3, 2, 0, 0, 0};

    rst = 1'b1; in_valid = 1'b0; sel = '0; def = '0; clr = 1'b0;
    set_items(0, 1, 2, 10, 6, 3);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // table-driven directed vectors
    for (int i = 0; i < 10; i++) begin
      in_valid = vt[i].v; clr = vt[i].clr; sel = 2'(vt[i].sel);
      if (vt[i].dup) set_items(1, 1, 2, 10, 6, 3);
      else set_items(0, 1, 2, 10, 6, 3);
      tick();
      chk($sformatf("vec%0d out_valid", i), int'(o_ov[0]), vt[i].e_ov);
      chk($sformatf("vec%0d data", i), int'(o_data[0]), vt[i].e_data);
      chk($sformatf("vec%0d hit_idx", i), int'(o_hit[0]), vt[i].e_hit);
      chk($sformatf("vec%0d unique nm_cnt", i), int'(o_nc[0]), vt[i].e_nc0);
      chk($sformatf("vec%0d unique nm_flag", i), int'(o_nf[0]), int'(vt[i].e_nc0 != 0));
      chk($sformatf("vec%0d unique0 mm_cnt", i), int'(o_mc[1]), vt[i].e_mc1);
      chk($sformatf("vec%0d unique0 nm_cnt", i), int'(o_nc[1]), 0);
      chk($sformatf("vec%0d priority nm_cnt", i), int'(o_nc[2]), vt[i].e_nc2);
      chk($sformatf("vec%0d priority mm_cnt", i), int'(o_mc[2]), 0);
      chk($sformatf("vec%0d priority data", i), int'(o_data[2]), vt[i].e_data);
    end
    clr = 1'b0;

    // saturation: 300 no-match samples
    set_items(0, 1, 2, 10, 6, 3);
    in_valid = 1'b1; sel = 2'd3;
    repeat (300) tick();
    chk("sat unique nm_cnt", int'(o_nc[0]), 255);
    chk("sat priority nm_cnt", int'(o_nc[2]), 255);
    chk("sat unique0 nm_cnt", int'(o_nc[1]), 0);
    chk("sat unique nm_flag", int'(o_nf[0]), 1);
    compare_model("sat");

    // reset pulsed mid-stream while in_valid toggles
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0]; sel = 2'(i);
      tick();
    end
    #2 rst = 1'b1;
    #1 check_all_zero("async rst");
    model_reset();
    @(posedge clk);
    #1 check_all_zero("held rst");
    rst = 1'b0;
    in_valid = 1'b1; sel = 2'd3;
    tick();
    chk("post rst out_valid", int'(o_ov[0]), 1);
    chk("post rst nm_cnt", int'(o_nc[0]), 1);
    compare_model("post rst");

    // randomized stimulus against the model
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      clr = 1'($urandom_range(0, 15) == 0);
      sel = 2'($urandom);
      def = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        k[i] = 2'($urandom);
        d[i] = 4'($urandom);
      end
      tick();
      compare_model($sformatf("rnd%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
